// File: rtl/rand_range_mapper.sv
// Maps a free-running random word onto an unbiased value in [0, RANGE-1]
// using rejection sampling followed by a bit-serial restoring remainder.
module rand_range_mapper #(
    parameter int WIDTH     = 13,
    parameter int RANGE     = 160,
    parameter int VALUE_W   = 8,
    parameter int MAX_TRIES = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   rnd_in,
    input  logic               req,
    output logic               busy,
    output logic               valid,
    output logic [VALUE_W-1:0] value
);

    localparam int SAFE_RANGE = (RANGE < 1) ? 1 : RANGE;
    localparam int SAFE_TRIES = (MAX_TRIES < 1) ? 1 : MAX_TRIES;
    localparam int LIMIT      = ((2 ** WIDTH) / SAFE_RANGE) * SAFE_RANGE;
    localparam int REM_W      = $clog2(SAFE_RANGE) + 1;
    localparam int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TRY_W      = $clog2(SAFE_TRIES + 1);

    localparam logic [WIDTH:0]   LIMIT_V     = (WIDTH + 1)'(LIMIT);
    localparam logic [REM_W:0]   RANGE_V     = (REM_W + 1)'(SAFE_RANGE);
    localparam logic [TRY_W-1:0] TRIES_MAX_V = TRY_W'(SAFE_TRIES);
    localparam logic [TRY_W-1:0] TRY_ONE     = TRY_W'(1);
    localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO    = IDX_W'(0);

    generate
        if (RANGE < 1 || RANGE > (2 ** VALUE_W) || RANGE > (2 ** WIDTH) || MAX_TRIES < 1) begin : g_param_err
            $error("rand_range_mapper: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_DIVIDE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sample_r;
    logic [TRY_W-1:0] tries_r;
    logic [IDX_W-1:0] idx_r;
    logic [REM_W-1:0] rem_r;

    logic             reject_s;
    logic [REM_W:0]   trial_s;
    logic [REM_W-1:0] rem_next_s;

    // Rejection decision and one restoring-remainder step on the current bit.
    always_comb begin
        reject_s   = 1'b0;
        trial_s    = {rem_r, sample_r[idx_r]};
        rem_next_s = {REM_W{1'b0}};
        if (({1'b0, sample_r} >= LIMIT_V) && (tries_r < TRIES_MAX_V)) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
        // rem < RANGE before the shift, so trial < 2*RANGE and one subtract suffices.
        if (trial_s >= RANGE_V) begin
            rem_next_s = REM_W'(trial_s - RANGE_V);
        end else begin
            rem_next_s = REM_W'(trial_s);
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            sample_r <= {WIDTH{1'b0}};
            tries_r  <= {TRY_W{1'b0}};
            idx_r    <= IDX_ZERO;
            rem_r    <= {REM_W{1'b0}};
            busy     <= 1'b0;
            valid    <= 1'b0;
            value    <= {VALUE_W{1'b0}};
        end else begin
            valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        sample_r <= rnd_in;
                        tries_r  <= TRY_ONE;
                        state_r  <= ST_CHECK;
                        busy     <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (reject_s) begin
                        sample_r <= rnd_in;
                        tries_r  <= tries_r + TRY_ONE;
                    end else begin
                        rem_r   <= {REM_W{1'b0}};
                        idx_r   <= IDX_TOP;
                        state_r <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    rem_r <= rem_next_s;
                    if (idx_r == IDX_ZERO) begin
                        value   <= VALUE_W'(rem_next_s);
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        idx_r <= idx_r - IDX_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_range_mapper.sv
// Directed bench for rand_range_mapper: a cycle-level reference model of the
// request/retry/result timing plus literal expectations for each scenario.
module tb_rand_range_mapper;

    localparam int WIDTH     = 13;
    localparam int RANGE     = 160;
    localparam int MAX_TRIES = 8;
    localparam int LIMIT     = (8192 / RANGE) * RANGE;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        req_b;
    logic [12:0] rnd_in;
    logic        busy, valid;
    logic [7:0]  value;
    logic        busy_a, valid_a, busy_b, valid_b;
    logic [7:0]  value_a, value_b;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    rand_range_mapper u_dut (
        .clock(clock), .reset(reset), .rnd_in(rnd_in), .req(req),
        .busy(busy), .valid(valid), .value(value)
    );

    rand_range_mapper #(.RANGE(1)) u_r1 (
        .clock(clock), .reset(reset), .rnd_in(rnd_in), .req(req_b),
        .busy(busy_a), .valid(valid_a), .value(value_a)
    );

    rand_range_mapper #(.RANGE(128)) u_r128 (
        .clock(clock), .reset(reset), .rnd_in(rnd_in), .req(req_b),
        .busy(busy_b), .valid(valid_b), .value(value_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: idle -> sampling (with retries) -> WIDTH-cycle countdown -> result.
    int   m_mode, m_tries, m_left, m_sample, m_result, m_value;
    logic m_valid, m_busy;

    always @(posedge clock) begin
        if (reset) begin
            m_mode <= 0; m_tries <= 0; m_left <= 0; m_sample <= 0;
            m_result <= 0; m_value <= 0; m_valid <= 1'b0; m_busy <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            case (m_mode)
                0: begin
                    if (req) begin
                        m_sample <= int'(rnd_in); m_tries <= 1; m_mode <= 1; m_busy <= 1'b1;
                    end else begin
                        m_busy <= 1'b0;
                    end
                end
                1: begin
                    m_busy <= 1'b1;
                    if (m_sample >= LIMIT && m_tries < MAX_TRIES) begin
                        m_sample <= int'(rnd_in); m_tries <= m_tries + 1;
                    end else begin
                        m_result <= m_sample % RANGE; m_left <= WIDTH; m_mode <= 2;
                    end
                end
                2: begin
                    if (m_left == 1) begin
                        m_value <= m_result; m_valid <= 1'b1; m_busy <= 1'b0; m_mode <= 0;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                default: m_mode <= 0;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("model_valid", int'(valid), int'(m_valid));
            check("model_busy",  int'(busy),  int'(m_busy));
            check("model_value", int'(value), m_value);
        end
    end

    // One request: w0 at the accept edge, w1 on every following cycle.
    task automatic run_req(input string name, input int w0, input int w1,
                           input int exp_val, input int exp_lat);
        int  lat;
        int  busy_cnt;
        bit  seen;
        req = 1'b1; rnd_in = 13'(w0);
        @(negedge clock);
        req = 1'b0; rnd_in = 13'(w1);
        lat = 0; seen = 1'b0;
        busy_cnt = busy ? 1 : 0;
        while (!seen && lat < 40) begin
            @(negedge clock);
            lat++;
            if (valid) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_value"}, int'(value), exp_val);
        check({name, "_busy_cycles"}, busy_cnt, exp_lat);
        @(negedge clock);
        check({name, "_valid_one_cycle"}, int'(valid), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int t[3];
        int cnt, n, nv, vi, la, lb;
        bit sa, sb;
        reset = 1'b1; req = 1'b0; req_b = 1'b0; rnd_in = 13'd0;
        repeat (2) @(negedge clock);
        cmp_en = 1'b1;
        check("reset_valid", int'(valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_value", int'(value), 0);
        reset = 1'b0;

        run_req("basic",   1000, 1000, 40,  14);
        run_req("reject",  8170, 325,  5,   15);
        run_req("exhaust", 8191, 8191, 31,  21);
        run_req("lim_m1",  8159, 8159, 159, 14);
        run_req("zero",    0,    0,    0,   14);
        run_req("lim",     8160, 160,  0,   15);

        // Reset in the middle of the remainder phase aborts the request.
        req = 1'b1; rnd_in = 13'd1000;
        @(negedge clock);
        req = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_valid", int'(valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_value", int'(value), 0);
        reset = 1'b0;
        run_req("post_rst", 1000, 1000, 40, 14);

        // req held high: results every WIDTH+2 cycles.
        req = 1'b1; rnd_in = 13'd1000;
        cnt = 0; n = 0; t[0] = 0; t[1] = 0; t[2] = 0;
        while (cnt < 3 && n < 80) begin
            @(negedge clock);
            n++;
            if (valid) begin t[cnt] = n; cnt++; end
        end
        req = 1'b0;
        check("held_gap1", t[1] - t[0], 15);
        check("held_gap2", t[2] - t[1], 15);
        check("held_value", int'(value), 40);
        repeat (2) @(negedge clock);

        // Extra pulses while busy are dropped.
        nv = 0; vi = -1;
        for (int i = 0; i < 40; i++) begin
            req = (i == 0 || i == 4 || i == 8);
            @(negedge clock);
            if (valid) begin nv++; vi = i; end
        end
        req = 1'b0;
        check("ignore_count", nv, 1);
        check("ignore_latency", vi, 14);

        // RANGE=1 and RANGE=128 instances: no rejection possible.
        req_b = 1'b1; rnd_in = 13'd8191;
        @(negedge clock);
        req_b = 1'b0;
        la = 0; lb = 0; sa = 1'b0; sb = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (valid_a && !sa) begin sa = 1'b1; la = i; end
            if (valid_b && !sb) begin sb = 1'b1; lb = i; end
        end
        check("r1_latency", la, 14);
        check("r1_value", int'(value_a), 0);
        check("r128_latency", lb, 14);
        check("r128_value", int'(value_b), 127);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
